// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: load/store funct3 encodings,
// writeback-source encodings, LSU state enum and access-size helpers.
package rv_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [2:0] ST_SB  = 3'b000;
    localparam logic [2:0] ST_SH  = 3'b001;
    localparam logic [2:0] ST_SW  = 3'b010;

    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // Unknown encodings fall back to a full word access.
    function automatic acc_size_e load_size(input logic [2:0] lt);
        case (lt)
            LT_LB, LT_LBU: load_size = SZ_BYTE;
            LT_LH, LT_LHU: load_size = SZ_HALF;
            default:       load_size = SZ_WORD;
        endcase
    endfunction

    function automatic acc_size_e store_size(input logic [2:0] st);
        case (st)
            ST_SB:   store_size = SZ_BYTE;
            ST_SH:   store_size = SZ_HALF;
            default: store_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the MEM stage: word-aligned address,
// store data replication and byte strobes, load lane select/extension,
// and misalignment detection.
module load_store_align
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_store,
    input  logic [2:0]      load_type,
    input  logic [2:0]      store_type,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] req_addr,
    output logic [XLEN-1:0] req_wdata,
    output logic [3:0]      req_wstrb,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    logic [1:0]      off_s;
    logic [XLEN-1:0] shifted_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;

    assign off_s     = addr[1:0];
    assign req_addr  = {addr[XLEN-1:2], 2'b00};
    assign shifted_s = rdata >> {off_s, 3'b000};
    assign byte_s    = shifted_s[7:0];
    assign half_s    = shifted_s[15:0];

    // Size check uses the store encoding for stores, the load encoding otherwise.
    always_comb begin
        if (is_store) begin
            misaligned = is_misaligned(store_size(store_type), off_s);
        end else begin
            misaligned = is_misaligned(load_size(load_type), off_s);
        end
    end

    // Store data is replicated across lanes; the strobe picks the live lane(s).
    always_comb begin
        req_wdata = wdata;
        req_wstrb = 4'b0000;
        if (is_store) begin
            case (store_type)
                ST_SB: begin
                    req_wdata = {(XLEN/8){wdata[7:0]}};
                    req_wstrb = 4'b0001 << off_s;
                end
                ST_SH: begin
                    req_wdata = {(XLEN/16){wdata[15:0]}};
                    req_wstrb = off_s[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    req_wdata = wdata;
                    req_wstrb = 4'b1111;
                end
            endcase
        end else begin
            req_wdata = wdata;
            req_wstrb = 4'b0000;
        end
    end

    // Select the addressed lane and sign/zero extend to the register width.
    always_comb begin
        case (load_type)
            LT_LB:   load_data = {{(XLEN-8){byte_s[7]}}, byte_s};
            LT_LH:   load_data = {{(XLEN-16){half_s[15]}}, half_s};
            LT_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_s};
            LT_LHU:  load_data = {{(XLEN-16){1'b0}}, half_s};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: valid/ready request FSM towards data memory,
// pipeline stall generation, misalignment trap and the MEM/WB register.
module mem_stage_lsu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [2:0]      LoadTypeM,
    input  logic [2:0]      StoreTypeM,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic [XLEN-1:0] ALU_ResultMEM,
    output logic            misaligned_exc,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW
);

    lsu_state_e      state_r;
    lsu_state_e      state_nxt_s;
    logic            is_store_s;
    logic            is_load_s;
    logic            mem_op_s;
    logic            misaligned_s;
    logic            bad_op_s;
    logic            good_op_s;
    logic            req_valid_s;
    logic            stall_s;
    logic [XLEN-1:0] load_data_s;

    // A store flag wins over a load-looking ResultSrc so one access is issued.
    assign is_store_s = MemWriteM;
    assign is_load_s  = (ResultSrcM == RS_LOAD) && !MemWriteM;
    assign mem_op_s   = is_store_s || is_load_s;
    assign good_op_s  = mem_op_s && !misaligned_s;
    assign bad_op_s   = (state_r == LSU_IDLE) && mem_op_s && misaligned_s;

    assign ALU_ResultMEM  = ALU_ResultM;
    assign StallM         = stall_s;
    assign dmem_req_valid = req_valid_s & rst;
    assign dmem_we        = req_valid_s & rst & is_store_s;

    load_store_align #(.XLEN(XLEN)) u_align (
        .is_store   (is_store_s),
        .load_type  (LoadTypeM),
        .store_type (StoreTypeM),
        .addr       (ALU_ResultM),
        .wdata      (WriteDataM),
        .rdata      (dmem_rdata),
        .req_addr   (dmem_addr),
        .req_wdata  (dmem_wdata),
        .req_wstrb  (dmem_wstrb),
        .load_data  (load_data_s),
        .misaligned (misaligned_s)
    );

    // Handshake decode: request valid, stall and next state per LSU state.
    always_comb begin
        state_nxt_s = state_r;
        req_valid_s = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            LSU_IDLE: begin
                if (good_op_s) begin
                    req_valid_s = 1'b1;
                    if (dmem_req_ready) begin
                        stall_s     = is_load_s;
                        state_nxt_s = is_load_s ? LSU_RESP : LSU_IDLE;
                    end else begin
                        stall_s     = 1'b1;
                        state_nxt_s = LSU_REQ;
                    end
                end else begin
                    req_valid_s = 1'b0;
                    stall_s     = 1'b0;
                    state_nxt_s = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                req_valid_s = 1'b1;
                if (dmem_req_ready) begin
                    stall_s     = is_load_s;
                    state_nxt_s = is_load_s ? LSU_RESP : LSU_IDLE;
                end else begin
                    stall_s     = 1'b1;
                    state_nxt_s = LSU_REQ;
                end
            end
            LSU_RESP: begin
                req_valid_s = 1'b0;
                if (dmem_rsp_valid) begin
                    stall_s     = 1'b0;
                    state_nxt_s = LSU_IDLE;
                end else begin
                    stall_s     = 1'b1;
                    state_nxt_s = LSU_RESP;
                end
            end
            default: begin
                req_valid_s = 1'b0;
                stall_s     = 1'b0;
                state_nxt_s = LSU_IDLE;
            end
        endcase
    end

    // LSU state register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // MEM/WB register: bubble on stall or misaligned access, else advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW      <= 1'b0;
            ResultSrcW     <= 2'b00;
            RD_W           <= 5'd0;
            PCPlus4W       <= {XLEN{1'b0}};
            ALU_ResultW    <= {XLEN{1'b0}};
            ReadDataW      <= {XLEN{1'b0}};
            misaligned_exc <= 1'b0;
        end else begin
            misaligned_exc <= bad_op_s;
            if (stall_s || bad_op_s) begin
                RegWriteW <= 1'b0;
            end else begin
                RegWriteW   <= RegWriteM;
                ResultSrcW  <= ResultSrcM;
                RD_W        <= RD_M;
                PCPlus4W    <= PCPlus4M;
                ALU_ResultW <= ALU_ResultM;
                if (state_r == LSU_RESP) begin
                    ReadDataW <= load_data_s;
                end else begin
                    ReadDataW <= ReadDataW;
                end
            end
        end
    end

endmodule
